reg_dump_reader: RTL and testbench

- Sequential reader on the register-file debug read port (debug_reg_ra / debug_reg_rd).
- On a start request it walks registers FIRST_REG..NUM_REGS-1 in address order and samples each value.
- Each value goes out as one beat on a valid/ready stream, tagged with its register address.
- Used by the debug/monitor path to dump architectural state while the core is paused; also produces a running XOR checksum of the dump.

---
 rtl/reg_dump_reader_pkg.sv | 17 +
 rtl/reg_dump_reader.sv | 116 +++++++++++
 tb/tb_reg_dump_reader.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/reg_dump_reader_pkg.sv
// Shared definitions for the register-dump reader.
//   state_t      : FSM state encoding (2 bits)
//   DEF_ADDR_W   : default register address width, shared with the register file
//   DEF_DATA_W   : default register data width, shared with the register file
package reg_dump_reader_pkg;

   localparam int DEF_ADDR_W = 5;
   localparam int DEF_DATA_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_SEND = 2'd2,
      ST_FIN  = 2'd3
   } state_t;

endpackage

// File: rtl/reg_dump_reader.sv
// Walks the register-file debug read port from FIRST_REG to NUM_REGS-1 and
// emits each value as one valid/ready beat tagged with its address. A running
// XOR of the beats is published on checksum when a dump completes.
// Ports:
//   clk, rstn           : clock, async active-low reset
//   start, abort        : dump request (IDLE only) / cancel
//   debug_reg_ra/_rd    : register-file debug read address / combinational data
//   out_valid/ready     : stream handshake
//   out_data/addr/last  : beat payload, address, last-beat flag
//   busy, done          : not-IDLE / one-cycle completion pulse
//   checksum            : XOR of all beats of the last completed dump
module reg_dump_reader
   import reg_dump_reader_pkg::*;
#(
   parameter int NUM_REGS  = 32,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int FIRST_REG = 0
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic              abort,
   output logic [ADDR_W-1:0] debug_reg_ra,
   input  logic [DATA_W-1:0] debug_reg_rd,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_last,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] checksum
);

   localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_REG);
   localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(NUM_REGS - 1);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] acc;
   logic              hs;

   assign hs = out_valid & out_ready;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // abort dominates everywhere except FIN, which always completes
   always_comb begin
      state_nxt    = state;
      debug_reg_ra = addr;
      out_valid    = 1'b0;
      busy         = 1'b1;
      done         = 1'b0;
      case (state)
         ST_IDLE: begin
            debug_reg_ra = FIRST_A;
            busy         = 1'b0;
            if (start && !abort) state_nxt = ST_READ;
         end
         ST_READ: begin
            state_nxt = abort ? ST_IDLE : ST_SEND;
         end
         ST_SEND: begin
            out_valid = 1'b1;
            if (abort)         state_nxt = ST_IDLE;
            else if (out_ready) state_nxt = out_last ? ST_FIN : ST_READ;
         end
         ST_FIN: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         addr     <= FIRST_A;
         acc      <= '0;
         out_data <= '0;
         out_addr <= '0;
         out_last <= 1'b0;
         checksum <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start && !abort) begin
                  addr <= FIRST_A;
                  acc  <= '0;
               end
            end
            ST_READ: begin
               if (!abort) begin
                  out_data <= debug_reg_rd;
                  out_addr <= addr;
                  out_last <= (addr == LAST_A);
               end
            end
            ST_SEND: begin
               // increment only below the last address, so addr never wraps
               if (hs && !abort) begin
                  acc <= acc ^ out_data;
                  if (!out_last) addr <= addr + 1'b1;
               end
            end
            ST_FIN: checksum <= acc;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_dump_reader.sv
module tb_reg_dump_reader;

   logic        clk = 1'b0;
   logic        rstn;
   logic        start, abort, out_ready;
   logic [4:0]  debug_reg_ra;
   logic [31:0] debug_reg_rd;
   logic        out_valid, out_last, busy, done;
   logic [31:0] out_data, checksum;
   logic [4:0]  out_addr;

   logic [31:0] rf [32];
   logic [31:0] ck_model;
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   assign debug_reg_rd = rf[debug_reg_ra];

   reg_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .FIRST_REG(0)) dut (
      .clk(clk), .rstn(rstn), .start(start), .abort(abort),
      .debug_reg_ra(debug_reg_ra), .debug_reg_rd(debug_reg_rd),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_addr(out_addr), .out_last(out_last), .busy(busy), .done(done),
      .checksum(checksum)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_valid"}, out_valid, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_data"}, out_data, 0);
      chk({tag, "_addr"}, out_addr, 0);
      chk({tag, "_last"}, out_last, 0);
      chk({tag, "_cksum"}, checksum, 0);
      chk({tag, "_ra"}, debug_reg_ra, 0);
   endtask

   // One dump; optional stall / restart pulse / concurrent write / abort / reset
   // at the given beat address (-1 disables). Inputs change on negedge only.
   task automatic run_dump(input int stall_at, input int restart_at, input int wr_at,
                           input int abort_at, input int rst_at);
      logic [31:0] acc;
      int          w;
      acc = 0;
      @(negedge clk); start = 1;
      @(negedge clk); start = 0;
      chk("busy_after_start", busy, 1);
      chk("ra_first_read", debug_reg_ra, 0);
      for (int a = 0; a < 32; a++) begin
         w = 0;
         while (!out_valid && w < 8) begin
            chk("no_early_done", done, 0);
            @(negedge clk);
            w++;
         end
         if (!out_valid) begin
            chk("valid_timeout", 0, 1);
            return;
         end
         chk("beat_gap", w, 1);
         chk("beat_addr", out_addr, a);
         chk("beat_data", out_data, rf[a]);
         chk("beat_last", out_last, a == 31);
         if (a == wr_at) rf[15] = 32'hCAFE_0001;
         if (a == 15 && wr_at >= 0) chk("conc_write_15", out_data, 32'hCAFE_0001);
         if (a == restart_at) start = 1;
         if (a == abort_at) begin
            abort = 1;
            @(negedge clk); abort = 0;
            chk("abort_busy", busy, 0);
            chk("abort_valid", out_valid, 0);
            chk("abort_done", done, 0);
            chk("abort_cksum", checksum, ck_model);
            @(negedge clk);
            chk("abort_no_done", done, 0);
            chk("abort_idle", busy, 0);
            return;
         end
         if (a == rst_at) begin
            rstn = 0;
            #1;
            chk_reset_outputs("async_rst");
            @(negedge clk); rstn = 1;
            ck_model = 0;
            return;
         end
         if (a == stall_at) begin
            out_ready = 0;
            repeat (5) begin
               @(negedge clk);
               chk("stall_valid", out_valid, 1);
               chk("stall_data", out_data, 32'hDEAD_BEEF);
               chk("stall_addr", out_addr, a);
            end
            out_ready = 1;
         end
         acc ^= rf[a];
         @(negedge clk); start = 0;
      end
      chk("done_pulse", done, 1);
      chk("cksum_before_fin", checksum, ck_model);
      ck_model = acc;
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("busy_end", busy, 0);
      chk("cksum_final", checksum, acc);
   endtask

   initial begin
      rstn = 0; start = 0; abort = 0; out_ready = 1; ck_model = 0;
      rf[0] = 32'h0;
      for (int i = 1; i < 32; i++) rf[i] = 32'h1000_0000 + i;
      #2;
      chk_reset_outputs("reset");
      @(negedge clk); rstn = 1;
      @(negedge clk);
      chk_reset_outputs("post_reset");

      // out_ready high while idle does nothing
      repeat (2) @(negedge clk);
      chk("ready_idle_valid", out_valid, 0);

      // start + abort together in IDLE: stay idle
      start = 1; abort = 1;
      @(negedge clk); start = 0; abort = 0;
      chk("start_abort_idle", busy, 0);
      @(negedge clk);
      chk("start_abort_idle2", busy, 0);

      // full dump; XOR of 0x1000_0000+i (i=1..31) is 0x1000_0000
      run_dump(-1, -1, -1, -1, -1);
      chk("cksum_const", checksum, 32'h1000_0000);

      // backpressure at addr 7
      rf[7] = 32'hDEAD_BEEF;
      run_dump(7, -1, -1, -1, -1);

      // abort at addr 10, then a fresh dump from 0
      run_dump(-1, -1, -1, 10, -1);
      run_dump(-1, -1, -1, -1, -1);

      // start while busy at addr 3
      run_dump(-1, 3, -1, -1, -1);

      // async reset at addr 20, then a clean dump
      run_dump(-1, -1, -1, -1, 20);
      @(negedge clk);
      chk("post_rst_idle", busy, 0);
      run_dump(-1, -1, -1, -1, -1);

      // concurrent write to reg 15 at addr 5
      run_dump(-1, -1, 5, -1, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
